dial_positioner: RTL and testbench
==================================

Name: dial_positioner

Overview:
Parametrised successor to the letter-dial motor path. It accepts a target dial position over a req/ready handshake and picks the shorter rotation direction. It walks the dial one position at a time, issuing the non-uniform per-position step count, and drives a 4-coil stepper in full-step or half-step mode. It keeps the absolute dial position and coil phase across moves, and sits between the ascii-to-position decode and the motor coils.

Parameters:
NPOS, 32, number of dial positions (even, >=4)
POS_W, 5, position width, clog2(NPOS)
BASE_STEPS, 6, full steps per dial segment
EXTRA_EVERY, 4, segment s gets BASE_STEPS+1 steps when s % EXTRA_EVERY == EXTRA_EVERY-1 (defaults give 200 steps/rev)
STEP_CYC, 1, drv_clk cycles per motor step (>=1)
CNT_W, 8, width of step/cycle counters

Ports:
drv_clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  1  move request, sampled only when ready=1
target_pos  in  POS_W  destination position, captured with req
half_mode  in  1  1 = half-step drive for this move, captured with req
stop  in  1  graceful abort: finish current segment, then end move
ready  out  1  idle, able to accept req
done  out  1  one-cycle pulse when a move ends (normal or stopped)
motor_drv  out  4  coil pattern
cur_pos  out  POS_W  absolute dial position, updated per segment
dir  out  1  1 = forward (increasing position), valid while busy
stopped  out  1  registered with done: move ended by stop before target

Behaviour:
- Reset (synchronous, active-high, clock drv_clk) applies in any state, including mid-move: state=IDLE, ready=1, done=0, stopped=0, motor_drv=0000, cur_pos=0, phase=0, dir=1, all counters 0.
- All outputs are registered.
- Phase index is 3 bits on an 8-entry table: 0001,0011,0010,0110,0100,1100,1000,1001. Full mode moves ±2 per step; half mode moves ±1 per step. Forward = +.
- Phase persists between moves.
- On accepting a full-mode move with phase odd, phase := phase & 3'b110. No coil output is produced for this adjust.
- IDLE: ready=1, motor_drv=0000 (de-energised). req=1 at an edge latches target_pos and half_mode, sets ready=0 and goes to PLAN. req while ready=0 is ignored.
- PLAN, 1 cycle:
  - d_f = (target - cur_pos) mod NPOS.
  - If d_f <= NPOS/2: dir=1, rem=d_f. Else dir=0, rem=NPOS-d_f. A tie goes forward.
  - rem=0 goes to DONE; otherwise go to SEG.
- SEG, 1 cycle:
  - Segment index s = cur_pos when dir=1, or (cur_pos-1) mod NPOS when dir=0.
  - seg_cnt = (BASE_STEPS + extra(s)) << half_mode.
  - Then go to STEP.
- STEP:
  - Every STEP_CYC cycles: phase steps in dir, motor_drv := table[new phase], seg_cnt--.
  - When seg_cnt reaches 0: cur_pos := cur_pos±1 mod NPOS (wraps NPOS-1 <-> 0), rem--.
  - Then: if rem=0 or stop was seen during the move, go to DONE; else go to SEG.
  - motor_drv holds its last pattern through SEG.
- stop is sticky once seen in PLAN/SEG/STEP. It never truncates a segment, so cur_pos is always a true dial position.
- DONE, 1 cycle: done=1, stopped=(rem!=0), motor_drv=0000, then IDLE with ready=1.
- Latency with req accepted at edge t:
  - Zero-distance move: done high in the cycle after edge t+2; ready=1 after edge t+3.
  - Nonzero move: total cycles = 2 + rem + STEP_CYC·Σseg_cnt.
- Counters never underflow: seg_cnt is reloaded only in SEG.

Decomposition:
- Package dial_pkg holds:
  - state enum IDLE/PLAN/SEG/STEP/DONE;
  - the 8-entry coil pattern constant;
  - function seg_steps(s, half) implementing BASE/EXTRA rule.
- One sub-module, coil_phase_gen: holds the phase register, takes step/dir/half/align inputs, and outputs the registered motor_drv pattern.

Test Plan:
- Reset, then target 1, full mode, STEP_CYC=1 -> dir=1; motor_drv 0010,0100,1000,0001,0010,0100 (6 steps); cur_pos=1; done pulse; stopped=0.
- From 0, target 31 -> dir=0; 7 steps 1000,0100,0010,0001,1000,0100,0010; cur_pos=31.
- From 0, target 16, then target 0 -> both forward (tie rule); 100 steps each; 200 total; final cur_pos=0; phase back to original.
- From 0, target 1 with half_mode=1 -> 12 steps starting 0011,0010,0110; next full-mode move first shows an even-phase pattern only.
- target = cur_pos -> no coil activity; done pulse after 3 cycles. req pulsed during a move -> ignored, move unaffected.
- From 0, target 8; assert stop mid-segment 2 -> segment completes; cur_pos=3, stopped=1. Reset asserted mid-STEP -> next cycle ready=1, motor_drv=0000, cur_pos=0.

Source files
------------

// File: rtl/dial_pkg.sv
// -----------------------------------------------------------------------------
// dial_pkg
// Shared definitions for the letter-dial positioner:
//   state_t     - controller states
//   COIL_TABLE  - 8-entry half-step coil pattern table, indexed by phase
//   seg_steps() - full/half step count for one dial segment
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package dial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    SEG,
    STEP,
    DONE
  } state_t;

  // Index 0 is the least significant nibble. Even phases energise one coil,
  // odd phases energise two neighbouring coils (half-step positions).
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  // Steps needed to cross segment s. Every extra_every-th segment carries one
  // extra full step so a revolution comes out at the motor's native count.
  function automatic int unsigned seg_steps(input int unsigned s,
                                            input logic        half,
                                            input int unsigned base,
                                            input int unsigned extra_every);
    int unsigned n;
    n = base;
    if ((s % extra_every) == (extra_every - 1)) begin
      n = n + 1;
    end
    if (half) begin
      n = n << 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/coil_phase_gen.sv
// -----------------------------------------------------------------------------
// coil_phase_gen
// Holds the stepper coil phase and drives the registered coil pattern.
// The phase survives between moves; only the coil output is de-energised.
// Ports:
//   drv_clk, reset  - clock, synchronous active-high reset
//   step_i          - advance the phase by one step this cycle
//   dir_i           - 1 = forward (phase increases)
//   half_i          - 1 = half-step (+-1), 0 = full-step (+-2)
//   align_i         - snap phase to the even (single-coil) position below it
//   deenergise_i    - force the coil output to 0000
//   motor_drv_o     - registered coil pattern
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module coil_phase_gen
  import dial_pkg::*;
(
  input  logic       drv_clk,
  input  logic       reset,
  input  logic       step_i,
  input  logic       dir_i,
  input  logic       half_i,
  input  logic       align_i,
  input  logic       deenergise_i,
  output logic [3:0] motor_drv_o
);

  logic [2:0] phase_q, phase_d;
  logic [3:0] drv_q, drv_d;
  logic [2:0] step_amt;

  always_comb begin
    phase_d  = phase_q;
    drv_d    = drv_q;
    step_amt = half_i ? 3'd1 : 3'd2;
    if (align_i) begin
      // Full-step moves must run on even phases; no coil output for this.
      phase_d = phase_q & 3'b110;
    end else if (step_i) begin
      phase_d = dir_i ? (phase_q + step_amt) : (phase_q - step_amt);
      drv_d   = COIL_TABLE[phase_d];
    end
    if (deenergise_i) begin
      drv_d = 4'b0000;
    end
  end

  always_ff @(posedge drv_clk) begin
    if (reset) begin
      phase_q <= 3'd0;
      drv_q   <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      drv_q   <= drv_d;
    end
  end

  assign motor_drv_o = drv_q;

endmodule

// File: rtl/dial_positioner.sv
// -----------------------------------------------------------------------------
// dial_positioner
// Moves the letter dial to a requested position by the shorter direction,
// one dial segment at a time, driving a 4-coil stepper in full- or half-step.
// Ports:
//   drv_clk, reset  - clock, synchronous active-high reset
//   req             - move request, taken only while ready=1
//   target_pos      - destination position (captured with req)
//   half_mode       - half-step drive for this move (captured with req)
//   stop            - graceful abort: finish the current segment, then end
//   ready           - idle and able to accept req
//   done            - one-cycle pulse when a move ends
//   motor_drv       - coil pattern
//   cur_pos         - absolute dial position, updated per completed segment
//   dir             - 1 = forward, valid while busy
//   stopped         - set with done when the move ended before the target
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dial_positioner
  import dial_pkg::*;
#(
  parameter int NPOS        = 32,
  parameter int POS_W       = 5,
  parameter int BASE_STEPS  = 6,
  parameter int EXTRA_EVERY = 4,
  parameter int STEP_CYC    = 1,
  parameter int CNT_W       = 8
) (
  input  logic             drv_clk,
  input  logic             reset,
  input  logic             req,
  input  logic [POS_W-1:0] target_pos,
  input  logic             half_mode,
  input  logic             stop,
  output logic             ready,
  output logic             done,
  output logic [3:0]       motor_drv,
  output logic [POS_W-1:0] cur_pos,
  output logic             dir,
  output logic             stopped
);

  state_t state_q, state_d;

  logic [POS_W-1:0] target_q, target_d;
  logic [POS_W-1:0] cur_pos_q, cur_pos_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic             half_q, half_d;
  logic             dir_q, dir_d;
  logic             stop_seen_q, stop_seen_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             stopped_q, stopped_d;

  logic             step_fire;
  logic             align;
  logic             deenergise;

  logic [POS_W:0]   dist_fwd;
  logic [POS_W:0]   dist_bwd;
  logic [POS_W-1:0] seg_idx;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] pos_dec;

  // Forward distance (target - cur) mod NPOS; one extra bit keeps the
  // wrap-around addition exact for any even NPOS.
  always_comb begin
    if (target_q >= cur_pos_q) begin
      dist_fwd = {1'b0, target_q} - {1'b0, cur_pos_q};
    end else begin
      dist_fwd = {1'b0, target_q} + (POS_W+1)'(NPOS) - {1'b0, cur_pos_q};
    end
    dist_bwd = (POS_W+1)'(NPOS) - dist_fwd;
  end

  assign pos_inc = (cur_pos_q == POS_W'(NPOS - 1)) ? '0 : cur_pos_q + 1'b1;
  assign pos_dec = (cur_pos_q == '0) ? POS_W'(NPOS - 1) : cur_pos_q - 1'b1;

  // Segment crossed next: the one ahead when forward, behind when backward.
  assign seg_idx = dir_q ? cur_pos_q : pos_dec;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cur_pos_d   = cur_pos_q;
    rem_d       = rem_q;
    half_d      = half_q;
    dir_d       = dir_q;
    stop_seen_d = stop_seen_q;
    seg_cnt_d   = seg_cnt_q;
    cyc_d       = cyc_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    stopped_d   = stopped_q;
    step_fire   = 1'b0;
    align       = 1'b0;
    deenergise  = 1'b0;

    if (state_q == PLAN || state_q == SEG || state_q == STEP) begin
      stop_seen_d = stop_seen_q | stop;
    end

    unique case (state_q)
      IDLE: begin
        if (ready_q && req) begin
          target_d    = target_pos;
          half_d      = half_mode;
          ready_d     = 1'b0;
          stop_seen_d = 1'b0;
          stopped_d   = 1'b0;
          align       = ~half_mode;
          state_d     = PLAN;
        end else begin
          // ready rises one cycle after returning to IDLE
          ready_d = 1'b1;
        end
      end

      PLAN: begin
        if (dist_fwd <= (POS_W+1)'(NPOS / 2)) begin
          dir_d = 1'b1;
          rem_d = dist_fwd[POS_W-1:0];
        end else begin
          dir_d = 1'b0;
          rem_d = dist_bwd[POS_W-1:0];
        end
        state_d = (dist_fwd == '0) ? DONE : SEG;
      end

      SEG: begin
        seg_cnt_d = CNT_W'(seg_steps(32'(seg_idx), half_q,
                                     BASE_STEPS, EXTRA_EVERY));
        cyc_d     = '0;
        state_d   = STEP;
      end

      STEP: begin
        if (cyc_q == CNT_W'(STEP_CYC - 1)) begin
          cyc_d     = '0;
          step_fire = 1'b1;
          seg_cnt_d = seg_cnt_q - 1'b1;
          if (seg_cnt_q == CNT_W'(1)) begin
            cur_pos_d = dir_q ? pos_inc : pos_dec;
            rem_d     = rem_q - 1'b1;
            if (rem_q == POS_W'(1) || stop_seen_q || stop) begin
              state_d = DONE;
            end else begin
              state_d = SEG;
            end
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      DONE: begin
        done_d     = 1'b1;
        stopped_d  = (rem_q != '0);
        deenergise = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge drv_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      cur_pos_q   <= '0;
      rem_q       <= '0;
      half_q      <= 1'b0;
      dir_q       <= 1'b1;
      stop_seen_q <= 1'b0;
      seg_cnt_q   <= '0;
      cyc_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      stopped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cur_pos_q   <= cur_pos_d;
      rem_q       <= rem_d;
      half_q      <= half_d;
      dir_q       <= dir_d;
      stop_seen_q <= stop_seen_d;
      seg_cnt_q   <= seg_cnt_d;
      cyc_q       <= cyc_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      stopped_q   <= stopped_d;
    end
  end

  coil_phase_gen u_coil (
    .drv_clk      (drv_clk),
    .reset        (reset),
    .step_i       (step_fire),
    .dir_i        (dir_q),
    .half_i       (half_q),
    .align_i      (align),
    .deenergise_i (deenergise),
    .motor_drv_o  (motor_drv)
  );

  assign ready   = ready_q;
  assign done    = done_q;
  assign cur_pos = cur_pos_q;
  assign dir     = dir_q;
  assign stopped = stopped_q;

endmodule

// File: tb/tb_dial_positioner.sv
`timescale 1ns/1ps
module tb_dial_positioner;

  localparam int POS_W = 5;

  logic             drv_clk;
  logic             reset;
  logic             req;
  logic [POS_W-1:0] target_pos;
  logic             half_mode;
  logic             stop;
  logic             ready;
  logic             done;
  logic [3:0]       motor_drv;
  logic [POS_W-1:0] cur_pos;
  logic             dir;
  logic             stopped;

  dial_positioner dut (
    .drv_clk    (drv_clk),
    .reset      (reset),
    .req        (req),
    .target_pos (target_pos),
    .half_mode  (half_mode),
    .stop       (stop),
    .ready      (ready),
    .done       (done),
    .motor_drv  (motor_drv),
    .cur_pos    (cur_pos),
    .dir        (dir),
    .stopped    (stopped)
  );

  initial drv_clk = 1'b0;
  always #5 drv_clk = ~drv_clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] pat [0:255];
  int         n_steps;
  int         n_cyc;
  logic       saw_done;
  logic       dir_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge drv_clk);
    reset = 1'b1;
    req   = 1'b0;
    stop  = 1'b0;
    @(posedge drv_clk);
    @(negedge drv_clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      if (ready === 1'b1) break;
      @(negedge drv_clk);
    end
  endtask

  // Issues one move and watches it to done. k counts cycles after the accept
  // edge; every new non-zero coil pattern is recorded as one step.
  task automatic run_move(input logic [POS_W-1:0] tgt, input logic hm,
                          input int stop_pos, input int glitch_k);
    logic [3:0] prev;
    int         sw;
    bit         sdone;
    wait_ready();
    req        = 1'b1;
    target_pos = tgt;
    half_mode  = hm;
    @(posedge drv_clk);
    @(negedge drv_clk);
    req      = 1'b0;
    prev     = 4'b0000;
    n_steps  = 0;
    n_cyc    = -1;
    saw_done = 1'b0;
    dir_seen = 1'bx;
    sw       = 0;
    sdone    = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1) dir_seen = dir;
      if (motor_drv !== prev && motor_drv !== 4'b0000) begin
        if (n_steps < 256) pat[n_steps] = motor_drv;
        n_steps++;
      end
      prev = motor_drv;
      if (done === 1'b1) begin
        saw_done = 1'b1;
        n_cyc    = k;
        break;
      end
      stop = 1'b0;
      if (stop_pos >= 0 && !sdone && cur_pos == POS_W'(stop_pos)) begin
        sw++;
        if (sw == 3) begin
          stop  = 1'b1;
          sdone = 1'b1;
        end
      end
      req        = (k == glitch_k);
      target_pos = (k == glitch_k) ? 5'd20 : tgt;
      @(negedge drv_clk);
    end
    stop = 1'b0;
    req  = 1'b0;
    check("done_seen", 32'(saw_done), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req        = 1'b0;
    target_pos = '0;
    half_mode  = 1'b0;
    stop       = 1'b0;
    repeat (2) @(posedge drv_clk);
    @(negedge drv_clk);
    reset = 1'b0;

    // Reset state
    check("rst_ready",   32'(ready),     32'd1);
    check("rst_done",    32'(done),      32'd0);
    check("rst_drv",     32'(motor_drv), 32'h0);
    check("rst_pos",     32'(cur_pos),   32'd0);
    check("rst_dir",     32'(dir),       32'd1);
    check("rst_stopped", 32'(stopped),   32'd0);

    // 0 -> 1 full step forward, segment 0 = 6 steps
    run_move(5'd1, 1'b0, -1, -1);
    check("m1_dir",     32'(dir_seen), 32'd1);
    check("m1_steps",   32'(n_steps),  32'd6);
    check("m1_pats",    {8'h0, pat[0], pat[1], pat[2], pat[3], pat[4], pat[5]}, 32'h00248124);
    check("m1_pos",     32'(cur_pos),  32'd1);
    check("m1_stopped", 32'(stopped),  32'd0);
    check("m1_cycles",  32'(n_cyc),    32'd9);
    check("m1_drv_off", 32'(motor_drv), 32'h0);
    check("m1_ready_lo", 32'(ready),   32'd0);
    $display("move 0->1 full: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // 0 -> 31 backward, segment 31 carries the extra step
    do_reset();
    run_move(5'd31, 1'b0, -1, -1);
    check("m2_dir",    32'(dir_seen), 32'd0);
    check("m2_steps",  32'(n_steps),  32'd7);
    check("m2_pats",   {4'h0, pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6]}, 32'h08421842);
    check("m2_pos",    32'(cur_pos),  32'd31);
    check("m2_cycles", 32'(n_cyc),    32'd10);
    $display("move 0->31 full: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // Half-revolution ties go forward; two of them make a full revolution
    do_reset();
    run_move(5'd16, 1'b0, -1, -1);
    check("m3a_dir",    32'(dir_seen), 32'd1);
    check("m3a_steps",  32'(n_steps),  32'd100);
    check("m3a_pos",    32'(cur_pos),  32'd16);
    check("m3a_cycles", 32'(n_cyc),    32'd118);
    check("m3a_last",   32'(pat[99]),  32'h1);
    $display("move 0->16 full: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);
    run_move(5'd0, 1'b0, -1, -1);
    check("m3b_dir",    32'(dir_seen), 32'd1);
    check("m3b_steps",  32'(n_steps),  32'd100);
    check("m3b_pos",    32'(cur_pos),  32'd0);
    check("m3b_first",  32'(pat[0]),   32'h2);
    check("m3b_last",   32'(pat[99]),  32'h1);
    $display("move 16->0 full: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // Half-step move, then a full-step move continues on even phases
    do_reset();
    run_move(5'd1, 1'b1, -1, -1);
    check("m4a_steps",  32'(n_steps), 32'd12);
    check("m4a_first3", {20'h0, pat[0], pat[1], pat[2]}, 32'h326);
    check("m4a_last",   32'(pat[11]), 32'h4);
    check("m4a_cycles", 32'(n_cyc),   32'd15);
    $display("move 0->1 half: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);
    run_move(5'd2, 1'b0, -1, -1);
    check("m4b_steps", 32'(n_steps), 32'd6);
    check("m4b_first", 32'(pat[0]),  32'h8);
    check("m4b_last",  32'(pat[5]),  32'h1);
    check("m4b_pos",   32'(cur_pos), 32'd2);
    $display("move 1->2 full: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // Zero-distance move
    run_move(5'd2, 1'b0, -1, -1);
    check("m5_steps",   32'(n_steps), 32'd0);
    check("m5_cycles",  32'(n_cyc),   32'd2);
    check("m5_stopped", 32'(stopped), 32'd0);
    check("m5_pos",     32'(cur_pos), 32'd2);
    check("m5_ready_lo", 32'(ready),  32'd0);
    @(negedge drv_clk);
    check("m5_ready_hi", 32'(ready),  32'd1);
    check("m5_done_lo",  32'(done),   32'd0);
    $display("move 2->2 zero: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // req pulsed mid-move is ignored: 2 -> 5 crosses segments 2,3,4
    run_move(5'd5, 1'b0, -1, 5);
    check("m6_steps",  32'(n_steps), 32'd19);
    check("m6_pos",    32'(cur_pos), 32'd5);
    check("m6_cycles", 32'(n_cyc),   32'd24);
    $display("move 2->5 full with stray req: steps=%0d cycles=%0d pos=%0d", n_steps, n_cyc, cur_pos);

    // Stop during segment 2 of 0 -> 8: segment finishes, move ends at 3
    do_reset();
    run_move(5'd8, 1'b0, 2, -1);
    check("m7_steps",   32'(n_steps), 32'd18);
    check("m7_pos",     32'(cur_pos), 32'd3);
    check("m7_stopped", 32'(stopped), 32'd1);
    check("m7_cycles",  32'(n_cyc),   32'd23);
    $display("move 0->8 stopped: steps=%0d cycles=%0d pos=%0d stopped=%0d", n_steps, n_cyc, cur_pos, stopped);

    // Reset in the middle of a step sequence
    do_reset();
    wait_ready();
    req        = 1'b1;
    target_pos = 5'd8;
    half_mode  = 1'b0;
    @(posedge drv_clk);
    @(negedge drv_clk);
    req = 1'b0;
    repeat (10) @(negedge drv_clk);
    check("m8_busy",    32'(ready),   32'd0);
    check("m8_pos_pre", 32'(cur_pos), 32'd1);
    reset = 1'b1;
    @(posedge drv_clk);
    @(negedge drv_clk);
    reset = 1'b0;
    check("m8_ready", 32'(ready),     32'd1);
    check("m8_drv",   32'(motor_drv), 32'h0);
    check("m8_pos",   32'(cur_pos),   32'd0);
    check("m8_done",  32'(done),      32'd0);
    $display("reset mid-move: ready=%0d drv=%b pos=%0d", ready, motor_drv, cur_pos);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
